// File: rtl/gen_teamplayer_if.sv
// Pin bundle between the port I/O block and the Team Player multitap:
// host handshake pins, pad inputs and the returned TL/D pins.
interface gen_teamplayer_if;
    logic        TH;
    logic        TR;
    logic [3:0]  PRESENT;
    logic [3:0]  SIX_BTN;
    logic [47:0] P_BTN;
    logic [3:0]  D;
    logic        TL;

    modport master (
        output TH, TR, PRESENT, SIX_BTN, P_BTN,
        input  D, TL
    );

    modport slave (
        input  TH, TR, PRESENT, SIX_BTN, P_BTN,
        output D, TL
    );
endinterface

// File: rtl/gen_teamplayer.sv
// Team Player multitap: shares one controller port among four pads, streaming a
// header, per-pad type nibbles and button nibbles over the TH/TR/TL handshake.
module gen_teamplayer #(
    parameter int ACK_DELAY = 4,
    parameter int TIMEOUT   = 2047
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            CE,
    gen_teamplayer_if.slave tp
);

    localparam int              TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      ACK_LAST = 4'(ACK_DELAY - 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PADS = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [3:0] type_nibble(input logic present, input logic six);
        logic [3:0] r;
        if (!present) begin
            r = 4'hF;
        end else if (six) begin
            r = 4'h1;
        end else begin
            r = 4'h0;
        end
        return r;
    endfunction

    // Pin order inside the 12-bit pad word is {Z,Y,X,MODE,START,C,B,A,RIGHT,LEFT,DOWN,UP}.
    function automatic logic [3:0] btn_nibble(input logic [11:0] b, input logic [2:0] sel);
        logic [3:0] r;
        case (sel)
            3'd0:    r = b[3:0];
            3'd1:    r = {b[7], b[4], b[6], b[5]};
            3'd2:    r = {b[8], b[9], b[10], b[11]};
            default: r = 4'hF;
        endcase
        return r;
    endfunction

    // Returns {found, pad} for the lowest present pad at or above 'from'.
    function automatic logic [2:0] find_pad(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if ((i >= int'(from)) && mask[i]) begin
                r = {1'b1, 2'(i)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [1:0]      pad_q, pad_d;
    logic            th_q, th_d, th_prev_q, th_prev_d, tr_q, tr_d;
    logic [3:0]      ack_cnt_q, ack_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [47:0]     snap_btn_q, snap_btn_d;
    logic [3:0]      snap_present_q, snap_present_d;
    logic [3:0]      snap_six_q, snap_six_d;
    logic [3:0]      d_q, d_d;
    logic            tl_q, tl_d;

    logic            th_fall_s, th_edge_s, pending_s, ack_s, timeout_s, last_nib_s;
    logic [2:0]      first_pad_s, next_pad_s;
    logic [1:0]      hdr_pad_s;
    logic [11:0]     cur_btn_s;
    logic [3:0]      nib_s;

    assign tp.D  = d_q;
    assign tp.TL = tl_q;

    // Handshake events; TH forcing and the TH fall take priority over acks and timeout.
    always_comb begin
        th_fall_s   = th_prev_q & ~th_q;
        th_edge_s   = th_prev_q ^ th_q;
        pending_s   = (state_q != ST_IDLE) && (tr_q != tl_q);
        ack_s       = CE && !th_q && !th_fall_s && pending_s && (ack_cnt_q == ACK_LAST);
        timeout_s   = CE && !th_q && !th_fall_s && (state_q != ST_IDLE) && (to_cnt_q == TO_LAST);
        cur_btn_s   = snap_btn_q[12*int'(pad_q) +: 12];
        last_nib_s  = snap_six_q[pad_q] ? (idx_q == 3'd2) : (idx_q == 3'd1);
        first_pad_s = find_pad(snap_present_q, 3'd0);
        next_pad_s  = find_pad(snap_present_q, {1'b0, pad_q} + 3'd1);
        hdr_pad_s   = 2'(idx_q - 3'd3);
    end

    // Nibble that the next ack will place on D.
    always_comb begin
        nib_s = 4'hF;
        case (state_q)
            ST_HDR: begin
                case (idx_q)
                    3'd0:       nib_s = 4'hF;
                    3'd1, 3'd2: nib_s = 4'h0;
                    default:    nib_s = type_nibble(snap_present_q[hdr_pad_s], snap_six_q[hdr_pad_s]);
                endcase
            end
            ST_PADS: nib_s = btn_nibble(cur_btn_s, idx_q);
            ST_DONE: nib_s = 4'hF;
            default: nib_s = 4'hF;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            pad_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pad_q   <= pad_d;
        end
    end

    // FSM next-state: header, then present pads in order, then the saturating DONE tail.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pad_d   = pad_q;
        if (!CE) begin
            state_d = state_q;
        end else if (th_q) begin
            state_d = ST_IDLE;
            idx_d   = 3'd0;
            pad_d   = 2'd0;
        end else if (th_fall_s) begin
            state_d = ST_HDR;
            idx_d   = 3'd0;
            pad_d   = 2'd0;
        end else if (ack_s) begin
            case (state_q)
                ST_HDR: begin
                    if (idx_q != 3'd6) begin
                        idx_d = idx_q + 3'd1;
                    end else if (first_pad_s[2]) begin
                        state_d = ST_PADS;
                        idx_d   = 3'd0;
                        pad_d   = first_pad_s[1:0];
                    end else begin
                        state_d = ST_DONE;
                        idx_d   = 3'd0;
                    end
                end
                ST_PADS: begin
                    if (!last_nib_s) begin
                        idx_d = idx_q + 3'd1;
                    end else if (next_pad_s[2]) begin
                        idx_d = 3'd0;
                        pad_d = next_pad_s[1:0];
                    end else begin
                        state_d = ST_DONE;
                        idx_d   = 3'd0;
                    end
                end
                ST_DONE: idx_d = idx_q;
                default: state_d = ST_IDLE;
            endcase
        end else if (timeout_s) begin
            state_d = ST_HDR;
            idx_d   = 3'd0;
            pad_d   = 2'd0;
        end else begin
            state_d = state_q;
        end
    end

    // FSM outputs: D and TL move together on an ack and are forced to idle while TH is high.
    always_comb begin
        d_d  = d_q;
        tl_d = tl_q;
        if (!CE) begin
            d_d = d_q;
        end else if (th_q) begin
            d_d  = 4'h3;
            tl_d = 1'b1;
        end else if (ack_s) begin
            d_d  = nib_s;
            tl_d = tr_q;
        end else begin
            d_d = d_q;
        end
    end

    // Input sampling, snapshot capture and the ack/timeout counters.
    always_comb begin
        th_d           = CE ? tp.TH : th_q;
        th_prev_d      = CE ? th_q : th_prev_q;
        tr_d           = CE ? tp.TR : tr_q;
        snap_btn_d     = snap_btn_q;
        snap_present_d = snap_present_q;
        snap_six_d     = snap_six_q;
        ack_cnt_d      = ack_cnt_q;
        to_cnt_d       = to_cnt_q;
        if (!CE) begin
            ack_cnt_d = ack_cnt_q;
        end else begin
            if (th_fall_s) begin
                snap_btn_d     = tp.P_BTN;
                snap_present_d = tp.PRESENT;
                snap_six_d     = tp.SIX_BTN;
            end else begin
                snap_btn_d = snap_btn_q;
            end
            if (th_q || th_fall_s || !pending_s || ack_s || timeout_s) begin
                ack_cnt_d = 4'd0;
            end else begin
                ack_cnt_d = ack_cnt_q + 4'd1;
            end
            if ((state_q == ST_IDLE) || th_q || th_edge_s || ack_s || timeout_s) begin
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            th_q           <= 1'b1;
            th_prev_q      <= 1'b1;
            tr_q           <= 1'b1;
            snap_btn_q     <= {48{1'b1}};
            snap_present_q <= 4'hF;
            snap_six_q     <= 4'hF;
            ack_cnt_q      <= 4'd0;
            to_cnt_q       <= '0;
            d_q            <= 4'h3;
            tl_q           <= 1'b1;
        end else begin
            th_q           <= th_d;
            th_prev_q      <= th_prev_d;
            tr_q           <= tr_d;
            snap_btn_q     <= snap_btn_d;
            snap_present_q <= snap_present_d;
            snap_six_q     <= snap_six_d;
            ack_cnt_q      <= ack_cnt_d;
            to_cnt_q       <= to_cnt_d;
            d_q            <= d_d;
            tl_q           <= tl_d;
        end
    end

endmodule

// File: tb/tb_gen_teamplayer.sv
// Self-checking bench for gen_teamplayer: table of full transfers plus
// hand-written sequences for glitches, CE stalls, timeout, TH abort and reset.
module tb_gen_teamplayer;

    localparam int ACK_DELAY = 4;
    localparam int TIMEOUT   = 2047;

    logic CLK = 1'b0;
    logic RESET;
    logic CE;

    gen_teamplayer_if tp();

    gen_teamplayer #(.ACK_DELAY(ACK_DELAY), .TIMEOUT(TIMEOUT)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .CE    (CE),
        .tp    (tp)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [3:0]  present;
        logic [3:0]  six;
        logic [47:0] btn;
        int          n;
        logic [79:0] nibs;
    } vec_t;

    vec_t       vecs [4];
    logic [3:0] exp_q [$];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // TL follows a TR toggle ACK_DELAY cycles after TR is registered, i.e. ACK_DELAY+1 after the pin edge.
    task automatic ack_expect(input string name, input logic [3:0] exp);
        int         cyc;
        logic [3:0] e;
        exp_q.push_back(exp);
        tp.TR = ~tp.TR;
        cyc = 0;
        while ((tp.TL !== tp.TR) && (cyc < 64)) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        e = exp_q.pop_front();
        chk({name, " ack"}, 32'(tp.TL), 32'(tp.TR));
        chk({name, " nibble"}, 32'(tp.D), 32'(e));
        chk({name, " latency"}, 32'(cyc), 32'(ACK_DELAY + 1));
    endtask

    task automatic start_transfer(input logic [3:0] present, input logic [3:0] six, input logic [47:0] btn);
        tp.TH = 1'b1;
        tp.TR = 1'b1;
        tp.PRESENT = present;
        tp.SIX_BTN = six;
        tp.P_BTN   = btn;
        tick(4);
        tp.TH = 1'b0;
        tick(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [79:0] tmp;
        logic [3:0]  d0;
        logic        tl0;
        int          cyc;

        vecs[0] = '{"one_3btn",  4'b0001, 4'b0000, {36'hFFF_FFF_FFF, 12'hFFE}, 11, 80'hF000_FFFE_FFF0_0000_0000};
        vecs[1] = '{"pad1_pad3", 4'b1010, 4'b1000, {12'h7FF, 36'hFFF_FFF_FFF}, 13, 80'hF00F_0F1F_FFFE_F000_0000};
        vecs[2] = '{"no_pads",   4'b0000, 4'b0000, {48{1'b1}},                  9, 80'hF00F_FFFF_F000_0000_0000};
        vecs[3] = '{"all_mixed", 4'b1111, 4'b0101, {12'hE17, 12'h0F0, 12'h3C9, 12'hA5C}, 18, 80'hF001_010C_659A_0F07_4F00};

        RESET = 1'b1;
        CE    = 1'b1;
        tp.TH = 1'b1;
        tp.TR = 1'b1;
        tp.PRESENT = 4'h0;
        tp.SIX_BTN = 4'h0;
        tp.P_BTN   = {48{1'b1}};
        tick(3);
        chk("reset D", 32'(tp.D), 32'h3);
        chk("reset TL", 32'(tp.TL), 32'h1);
        RESET = 1'b0;
        tick(3);
        chk("idle D", 32'(tp.D), 32'h3);
        chk("idle TL", 32'(tp.TL), 32'h1);

        // Pad inputs are inverted right after the TH fall to prove only the snapshot is used.
        for (int v = 0; v < 4; v++) begin
            start_transfer(vecs[v].present, vecs[v].six, vecs[v].btn);
            chk({vecs[v].name, " hdr entry D"}, 32'(tp.D), 32'h3);
            tp.P_BTN   = ~vecs[v].btn;
            tp.PRESENT = ~vecs[v].present;
            tp.SIX_BTN = ~vecs[v].six;
            tmp = vecs[v].nibs;
            for (int k = 0; k < vecs[v].n; k++) begin
                ack_expect($sformatf("%s n%0d", vecs[v].name, k), tmp[79-4*k -: 4]);
            end
        end

        start_transfer(4'b0001, 4'b0000, {36'hFFF_FFF_FFF, 12'hFFE});
        ack_expect("glitch h0", 4'hF);
        ack_expect("glitch h1", 4'h0);
        d0  = tp.D;
        tl0 = tp.TL;
        tp.TR = ~tp.TR;
        tick(ACK_DELAY - 1);
        tp.TR = ~tp.TR;
        tick(ACK_DELAY + 4);
        chk("glitch TL held", 32'(tp.TL), 32'(tl0));
        chk("glitch D held", 32'(tp.D), 32'(d0));
        ack_expect("glitch h2", 4'h0);

        CE  = 1'b0;
        d0  = tp.D;
        tl0 = tp.TL;
        exp_q.push_back(4'h0);
        tp.TR = ~tp.TR;
        tick(20);
        tp.TH = 1'b1;
        tick(5);
        chk("ce-low TL held", 32'(tp.TL), 32'(tl0));
        chk("ce-low D held", 32'(tp.D), 32'(d0));
        tp.TH = 1'b0;
        CE = 1'b1;
        cyc = 0;
        while ((tp.TL !== tp.TR) && (cyc < 64)) begin
            tick(1);
            cyc++;
        end
        chk("ce-resume ack", 32'(tp.TL), 32'(tp.TR));
        chk("ce-resume nibble", 32'(tp.D), 32'(exp_q.pop_front()));
        ack_expect("ce-resume t1", 4'hF);

        start_transfer(4'b0001, 4'b0000, {48{1'b1}});
        ack_expect("to h0", 4'hF);
        ack_expect("to h1", 4'h0);
        ack_expect("to h2", 4'h0);
        tick(TIMEOUT - 20);
        ack_expect("to no-expire t0", 4'h0);
        tl0 = tp.TL;
        tick(TIMEOUT + 10);
        chk("to D held", 32'(tp.D), 32'h0);
        chk("to TL held", 32'(tp.TL), 32'(tl0));
        ack_expect("to restart h0", 4'hF);
        ack_expect("to restart h1", 4'h0);
        tp.TH = 1'b1;
        tick(2);
        chk("th-abort D", 32'(tp.D), 32'h3);
        chk("th-abort TL", 32'(tp.TL), 32'h1);

        tp.TR = 1'b1;
        tick(2);
        start_transfer(4'b0001, 4'b0000, {48{1'b1}});
        ack_expect("rst h0", 4'hF);
        ack_expect("rst h1", 4'h0);
        RESET = 1'b1;
        tp.TH = 1'b1;
        tp.TR = 1'b1;
        #1;
        chk("rst async D", 32'(tp.D), 32'h3);
        chk("rst async TL", 32'(tp.TL), 32'h1);
        tick(1);
        chk("rst next D", 32'(tp.D), 32'h3);
        chk("rst next TL", 32'(tp.TL), 32'h1);
        RESET = 1'b0;
        tick(3);
        chk("post-rst D", 32'(tp.D), 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
